// File: rtl/traffic_lights_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lights_cmd_arb
// Description : Boot sequencer and round-robin command arbiter in front of
//               traffic_lights. After reset it loads the default green, red
//               and yellow times and switches the lights on. It then shares
//               the single command port between N_REQ requesters and drops
//               illegal command codes (6/7), counting them in drop_cnt_o.
//               Optional feature macro: TL_CMD_ARB_OFF_LOCK_EN. When it is
//               defined, an "off" command locks arbitration to its sender
//               until that sender issues "on".
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lights_cmd_arb #(
    parameter int          N_REQ         = 2,
    parameter logic [15:0] DEF_GREEN_MS  = 16'd10,
    parameter logic [15:0] DEF_RED_MS    = 16'd10,
    parameter logic [15:0] DEF_YELLOW_MS = 16'd3
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [3*N_REQ-1:0]    req_type_i,
    input  logic [16*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [2:0]            cmd_type_o,
    output logic                  cmd_valid_o,
    output logic [15:0]           cmd_data_o,
    output logic                  boot_done_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] c_st_boot_g  = 3'd0;
    localparam logic [2:0] c_st_boot_r  = 3'd1;
    localparam logic [2:0] c_st_boot_y  = 3'd2;
    localparam logic [2:0] c_st_boot_on = 3'd3;
    localparam logic [2:0] c_st_run     = 3'd4;

    localparam logic [2:0] c_cmd_on      = 3'd0;
    localparam logic [2:0] c_cmd_off     = 3'd1;
    localparam logic [2:0] c_cmd_green   = 3'd3;
    localparam logic [2:0] c_cmd_red     = 3'd4;
    localparam logic [2:0] c_cmd_yellow  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_ptr_w-1:0]  r_ptr;
    logic [2:0]          r_cmd_type;
    logic                r_cmd_valid;
    logic [15:0]         r_cmd_data;
    logic                r_boot_done;
    logic [7:0]          r_drop_cnt;

    logic                w_boot_issue;
    logic [2:0]          w_boot_type;
    logic [15:0]         w_boot_data;
    logic                w_run;

    logic [N_REQ-1:0]    w_eligible;
    logic [N_REQ-1:0]    w_grant_oh;
    logic                w_grant_any;
    logic [c_ptr_w-1:0]  w_grant_idx;
    logic [2:0]          w_sel_type;
    logic [15:0]         w_sel_data;
    logic                w_xfer;
    logic                w_legal;

`ifdef TL_CMD_ARB_OFF_LOCK_EN
    logic                r_locked;
    logic [c_ptr_w-1:0]  r_lock_id;

    // While locked only the lock owner may compete for the port
    always_comb begin : p_eligible
        w_eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = req_valid_i[i] && (!r_locked || (r_lock_id == c_ptr_w'(i)));
        end
    end
`else
    assign w_eligible = req_valid_i;
`endif

    // Round-robin pick: the eligible requester closest to ptr (ascending, wrapping)
    always_comb begin : p_arb
        int v_dist;
        int v_best;
        v_dist      = 0;
        v_best      = N_REQ;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        w_sel_type  = 3'd0;
        w_sel_data  = 16'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(r_ptr)) begin
                v_dist = i - int'(r_ptr);
            end else begin
                v_dist = i + N_REQ - int'(r_ptr);
            end
            if (w_eligible[i] && (v_dist < v_best)) begin
                v_best        = v_dist;
                w_grant_any   = 1'b1;
                w_grant_idx   = c_ptr_w'(i);
                w_grant_oh    = '0;
                w_grant_oh[i] = 1'b1;
                w_sel_type    = req_type_i[3*i +: 3];
                w_sel_data    = req_data_i[16*i +: 16];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= c_st_boot_g;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: one cycle per boot step, RUN is terminal
    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot_g:  w_state_nxt = c_st_boot_r;
            c_st_boot_r:  w_state_nxt = c_st_boot_y;
            c_st_boot_y:  w_state_nxt = c_st_boot_on;
            c_st_boot_on: w_state_nxt = c_st_run;
            c_st_run:     w_state_nxt = c_st_run;
            default:      w_state_nxt = c_st_boot_g;
        endcase
    end

    // State outputs: boot command to issue, or permission to arbitrate
    always_comb begin : p_fsm_out
        w_boot_issue = 1'b0;
        w_boot_type  = c_cmd_on;
        w_boot_data  = 16'd0;
        w_run        = 1'b0;
        case (r_state)
            c_st_boot_g: begin
                w_boot_issue = 1'b1;
                w_boot_type  = c_cmd_green;
                w_boot_data  = DEF_GREEN_MS;
            end
            c_st_boot_r: begin
                w_boot_issue = 1'b1;
                w_boot_type  = c_cmd_red;
                w_boot_data  = DEF_RED_MS;
            end
            c_st_boot_y: begin
                w_boot_issue = 1'b1;
                w_boot_type  = c_cmd_yellow;
                w_boot_data  = DEF_YELLOW_MS;
            end
            c_st_boot_on: begin
                w_boot_issue = 1'b1;
                w_boot_type  = c_cmd_on;
                w_boot_data  = 16'd0;
            end
            c_st_run: w_run = 1'b1;
            default: ;
        endcase
    end

    assign req_ready_o = w_run ? w_grant_oh : '0;
    assign w_xfer      = w_run && w_grant_any;
    assign w_legal     = !(w_sel_type[2] && w_sel_type[1]);

    // Command register: boot commands first, then legal granted requests
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cmd_type  <= 3'd0;
            r_cmd_data  <= 16'd0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_boot_issue) begin
                r_cmd_type  <= w_boot_type;
                r_cmd_data  <= w_boot_data;
                r_cmd_valid <= 1'b1;
            end else if (w_xfer && w_legal) begin
                r_cmd_type  <= w_sel_type;
                r_cmd_data  <= w_sel_data;
                r_cmd_valid <= 1'b1;
            end
        end
    end

    // Pointer moves past the requester just served; held otherwise
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            if (w_grant_idx == c_ptr_w'(N_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + 1'b1;
            end
        end
    end

    // Status: boot completion flag and saturating drop counter
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_boot_done <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            if (r_state == c_st_run) begin
                r_boot_done <= 1'b1;
            end
            if (w_xfer && !w_legal && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

`ifdef TL_CMD_ARB_OFF_LOCK_EN
    // Off locks the port to its sender; on from the owner releases it
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_xfer) begin
            if (w_sel_type == c_cmd_off) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_grant_idx;
            end else if (w_sel_type == c_cmd_on) begin
                r_locked  <= 1'b0;
            end
        end
    end
`endif

    assign cmd_type_o  = r_cmd_type;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_data_o  = r_cmd_data;
    assign boot_done_o = r_boot_done;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_lights_cmd_arb
// Description : Randomised self-checking bench for traffic_lights_cmd_arb
//               with a transaction-level reference model. Honours the
//               TL_CMD_ARB_OFF_LOCK_EN macro in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_cmd_arb;

    localparam int          N     = 3;
    localparam logic [15:0] G_MS  = 16'd25;
    localparam logic [15:0] R_MS  = 16'd40;
    localparam logic [15:0] Y_MS  = 16'd7;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [3*N-1:0]    req_type = '0;
    logic [16*N-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic [2:0]        cmd_type;
    logic              cmd_valid;
    logic [15:0]       cmd_data;
    logic              boot_done;
    logic [7:0]        drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_step;
    int          m_ptr;
    int          m_drop;
    int          m_lock_id;
    bit          m_locked;
    bit          m_valid;
    bit          m_boot_done;
    logic [2:0]  m_type;
    logic [15:0] m_data;
    logic [N-1:0] e_ready;
    logic [N-1:0] o_ready;

    traffic_lights_cmd_arb #(
        .N_REQ        (N),
        .DEF_GREEN_MS (G_MS),
        .DEF_RED_MS   (R_MS),
        .DEF_YELLOW_MS(Y_MS)
    ) dut (
        .clk_i      (clk),
        .arst_i     (arst),
        .req_valid_i(req_valid),
        .req_type_i (req_type),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .cmd_type_o (cmd_type),
        .cmd_valid_o(cmd_valid),
        .cmd_data_o (cmd_data),
        .boot_done_o(boot_done),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_step = 0; m_ptr = 0; m_drop = 0; m_lock_id = 0; m_locked = 0;
        m_valid = 0; m_boot_done = 0; m_type = 3'd0; m_data = 16'd0;
    endtask

    // Search from ptr upward with wrap for the first valid, unmasked requester
    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (v[j] && (!m_locked || j == m_lock_id)) return j;
        end
        return -1;
    endfunction

    // Drive one cycle at posedge+1, capture ready, advance model over the edge
    task automatic cycle(input logic [N-1:0] v, input logic [3*N-1:0] t, input logic [16*N-1:0] d);
        int g;
        int ty;
        req_valid = v; req_type = t; req_data = d;
        #1;
        o_ready = req_ready;
        g = (m_step < 4) ? -1 : model_grant(v);
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        @(posedge clk);
        if (m_step < 4) begin
            m_valid = 1;
            case (m_step)
                0: begin m_type = 3'd3; m_data = G_MS; end
                1: begin m_type = 3'd4; m_data = R_MS; end
                2: begin m_type = 3'd5; m_data = Y_MS; end
                default: begin m_type = 3'd0; m_data = 16'd0; end
            endcase
            m_step++;
        end else begin
            m_boot_done = 1;
            m_valid = 0;
            if (g >= 0) begin
                ty = int'(t[3*g +: 3]);
                if (ty <= 5) begin
                    m_valid = 1; m_type = 3'(ty); m_data = d[16*g +: 16];
                end else if (m_drop < 255) begin
                    m_drop++;
                end
                m_ptr = (g + 1) % N;
`ifdef TL_CMD_ARB_OFF_LOCK_EN
                if (ty == 1) begin m_locked = 1; m_lock_id = g; end
                else if (ty == 0) m_locked = 0;
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cmd_valid !== 1'b0 || cmd_type !== 3'd0 || cmd_data !== 16'd0) begin n_err++; $display("FAIL reset_cmd: got v=%b t=%0d d=%0d want 0/0/0", cmd_valid, cmd_type, cmd_data); end
        n_cmp++; if (boot_done !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_status: got boot_done=%b drop=%0d want 0/0", boot_done, drop_cnt); end
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        arst = 1'b0;
        model_reset();
    endtask

    task automatic test_boot();
        for (int c = 0; c < 7; c++) begin
            cycle('0, '0, '0);
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL boot_ready c%0d: got %b want %b", c, o_ready, e_ready); end
            n_cmp++; if (cmd_valid !== m_valid) begin n_err++; $display("FAIL boot_valid c%0d: got %b want %b", c, cmd_valid, m_valid); end
            n_cmp++; if (cmd_type !== m_type || cmd_data !== m_data) begin n_err++; $display("FAIL boot_cmd c%0d: got %0d/%0d want %0d/%0d", c, cmd_type, cmd_data, m_type, m_data); end
            n_cmp++; if (boot_done !== m_boot_done) begin n_err++; $display("FAIL boot_done c%0d: got %b want %b", c, boot_done, m_boot_done); end
        end
    endtask

    task automatic test_round_robin();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        t = '0; d = '0;
        t[2:0] = 3'd3; t[5:3] = 3'd4;
        d[15:0] = 16'd20; d[31:16] = 16'd30;
        for (int c = 0; c < 6; c++) begin
            cycle(3'b011, t, d);
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL rr_ready c%0d: got %b want %b", c, o_ready, e_ready); end
            n_cmp++; if (cmd_valid !== m_valid || cmd_type !== m_type || cmd_data !== m_data) begin n_err++; $display("FAIL rr_cmd c%0d: got %b/%0d/%0d want %b/%0d/%0d", c, cmd_valid, cmd_type, cmd_data, m_valid, m_type, m_data); end
        end
    endtask

    task automatic test_illegal();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        t = '0; d = '0;
        t[5:3] = 3'd6; d[31:16] = 16'd5;
        cycle(3'b010, t, d);
        n_cmp++; if (o_ready !== 3'b010) begin n_err++; $display("FAIL illegal_ready: got %b want 010", o_ready); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL illegal_valid: got %b want 0", cmd_valid); end
        n_cmp++; if (drop_cnt !== 8'(m_drop) || m_drop != 1) begin n_err++; $display("FAIL illegal_drop: got %0d want %0d", drop_cnt, m_drop); end
        n_cmp++; if (cmd_type !== m_type || cmd_data !== m_data) begin n_err++; $display("FAIL illegal_hold: got %0d/%0d want %0d/%0d", cmd_type, cmd_data, m_type, m_data); end
    endtask

    task automatic test_saturation();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        for (int c = 0; c < 262; c++) begin
            t = '0; d = '0;
            t[5:3] = 3'(6 + (c % 2)); d[31:16] = 16'($urandom);
            cycle(3'b010, t, d);
            n_cmp++; if (cmd_valid !== 1'b0 || drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL sat c%0d: got v=%b drop=%0d want v=0 drop=%0d", c, cmd_valid, drop_cnt, m_drop); end
        end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        t = '0; d = '0;
        t[2:0] = 3'd5;
        for (int c = 0; c < 3; c++) begin
            d[15:0] = 16'($urandom);
            cycle(3'b001, t, d);
        end
        n_cmp++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got v=%b want 1", cmd_valid); end
        arst = 1'b1;
        #2;
        n_cmp++; if (cmd_valid !== 1'b0 || cmd_type !== 3'd0 || cmd_data !== 16'd0 || drop_cnt !== 8'd0 || boot_done !== 1'b0) begin n_err++; $display("FAIL midrst_async: got v=%b t=%0d d=%0d drop=%0d bd=%b want all 0", cmd_valid, cmd_type, cmd_data, drop_cnt, boot_done); end
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        model_reset();
        for (int c = 0; c < 7; c++) begin
            cycle(3'b001, t, d);
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL midrst_ready c%0d: got %b want %b", c, o_ready, e_ready); end
            n_cmp++; if (cmd_valid !== m_valid || cmd_type !== m_type || cmd_data !== m_data) begin n_err++; $display("FAIL midrst_cmd c%0d: got %b/%0d/%0d want %b/%0d/%0d", c, cmd_valid, cmd_type, cmd_data, m_valid, m_type, m_data); end
            n_cmp++; if (boot_done !== m_boot_done) begin n_err++; $display("FAIL midrst_bd c%0d: got %b want %b", c, boot_done, m_boot_done); end
        end
    endtask

    task automatic test_boot_request();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        int first;
        t = '0; d = '0;
        t[2:0] = 3'd3; d[15:0] = 16'h1234;
        first = -1;
        test_reset();
        cycle('0, '0, '0);
        for (int c = 0; c < 6 && first < 0; c++) begin
            cycle(3'b001, t, d);
            if (o_ready[0] === 1'b1) first = c;
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL bootreq_ready c%0d: got %b want %b", c, o_ready, e_ready); end
        end
        n_cmp++; if (first != 3) begin n_err++; $display("FAIL bootreq_first: got cycle %0d want 3", first); end
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_type !== 3'd3 || cmd_data !== 16'h1234) begin n_err++; $display("FAIL bootreq_cmd: got %b/%0d/%h want 1/3/1234", cmd_valid, cmd_type, cmd_data); end
        cycle('0, '0, '0);
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL bootreq_after: got v=%b want 0", cmd_valid); end
    endtask

    task automatic test_random();
        bit          p_valid[N];
        logic [2:0]  p_type[N];
        logic [15:0] p_data[N];
        logic [N-1:0]    v;
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        for (int i = 0; i < N; i++) begin p_valid[i] = 0; p_type[i] = '0; p_data[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    p_valid[i] = 1; p_type[i] = 3'($urandom_range(0, 7)); p_data[i] = 16'($urandom);
                end else if (p_valid[i] && ($urandom_range(0, 15) == 0)) begin
                    p_valid[i] = 0;
                end
                v[i] = p_valid[i];
                t[3*i +: 3] = p_type[i];
                d[16*i +: 16] = p_data[i];
            end
            cycle(v, t, d);
            for (int i = 0; i < N; i++) if (e_ready[i]) p_valid[i] = 0;
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, o_ready, e_ready); end
            n_cmp++; if (cmd_valid !== m_valid || cmd_type !== m_type || cmd_data !== m_data) begin n_err++; $display("FAIL rand_cmd c%0d: got %b/%0d/%0d want %b/%0d/%0d", c, cmd_valid, cmd_type, cmd_data, m_valid, m_type, m_data); end
            n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL rand_drop c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
        end
    endtask

`ifdef TL_CMD_ARB_OFF_LOCK_EN
    task automatic test_lock();
        logic [3*N-1:0]  t;
        logic [16*N-1:0] d;
        bit got;
        t = '0; d = '0;
        t[2:0] = 3'd1; t[5:3] = 3'd3; d[31:16] = 16'd77;
        got = 0;
        for (int c = 0; c < 4 && !got; c++) begin
            cycle(got ? 3'b010 : 3'b011, t, d);
            if (o_ready[0] === 1'b1) got = 1;
            n_cmp++; if (o_ready !== e_ready) begin n_err++; $display("FAIL lock_acq c%0d: got %b want %b", c, o_ready, e_ready); end
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL lock_grant0: got no grant want grant to req0"); end
        for (int c = 0; c < 5; c++) begin
            cycle(3'b010, t, d);
            n_cmp++; if (o_ready[1] !== 1'b0) begin n_err++; $display("FAIL lock_hold c%0d: got ready1=%b want 0", c, o_ready[1]); end
        end
        t[2:0] = 3'd0;
        cycle(3'b011, t, d);
        n_cmp++; if (o_ready !== 3'b001) begin n_err++; $display("FAIL lock_on: got %b want 001", o_ready); end
        cycle(3'b010, t, d);
        n_cmp++; if (o_ready !== 3'b010) begin n_err++; $display("FAIL lock_release: got %b want 010", o_ready); end
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 16'd77) begin n_err++; $display("FAIL lock_cmd: got %b/%0d want 1/77", cmd_valid, cmd_data); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_boot();
        test_round_robin();
        test_illegal();
        test_saturation();
        test_reset_mid();
        test_boot_request();
`ifdef TL_CMD_ARB_OFF_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
